regfile_wb_arbiter: RTL

- Shares the register file's single write port between several writeback sources (EXU result, LSU load data, CSR read data) using a valid/ready handshake.
- Uses round-robin arbitration. The winning request is registered and presented on the regfile write port one cycle later.
- Sits between the execute/memory stages and regfile. Its outputs connect directly to register_write_enable, register_write_addr and register_write_data.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the regfile writeback arbiter: requester indices and
// register-file bus constants.
package regfile_wb_arbiter_pkg;

  localparam int WB_NUM_REQ = 3;
  localparam int REG_XLEN   = 64;

  typedef enum logic [1:0] {
    WB_REQ_EXU = 2'd0,
    WB_REQ_LSU = 2'd1,
    WB_REQ_CSR = 2'd2
  } wb_req_e;

  localparam logic [REG_XLEN-1:0] ZERO_WORD        = 64'h0;
  localparam logic [4:0]          REGISTER_X0      = 5'd0;
  localparam logic                REG_WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found scanning
// upward from rr_ptr and wrapping back to index 0.
module regfile_wb_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j >= int'(rr_ptr))) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j < int'(rr_ptr))) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between EXU, LSU and CSR writeback sources with
// round-robin arbitration and a one-cycle registered write port.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int XLEN    = REG_XLEN,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    register_write_enable,
  output logic [4:0]              register_write_addr,
  output logic [XLEN-1:0]         register_write_data,
  output logic [CNT_W-1:0]        conflict_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [4:0]      addr_arr [NUM_REQ];
  logic [XLEN-1:0] data_arr [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W:0]     n_valid;
  logic               transfer;
  logic               multi_valid;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[5*gi +: 5];
    assign data_arr[gi] = req_data[XLEN*gi +: XLEN];
  end

  regfile_wb_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Readiness is masked during reset so nothing can complete in the reset cycle.
  assign req_ready = (rst || wb_hold) ? '0 : grant;
  assign transfer  = |req_ready;

  // Number of requesters asserting valid this cycle.
  always_comb begin
    n_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      n_valid = n_valid + (IDX_W+1)'(req_valid[j]);
    end
  end

  assign multi_valid = (n_valid >= (IDX_W+1)'(2));

  // Round-robin pointer moves past the winner only when a transfer happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Output register; an x0 destination is accepted but never enables the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      register_write_enable <= 1'b0;
      register_write_addr   <= REGISTER_X0;
      register_write_data   <= XLEN'(ZERO_WORD);
    end else if (transfer) begin
      register_write_enable <= (addr_arr[grant_idx] != REGISTER_X0) ? REG_WRITE_ENABLE : 1'b0;
      register_write_addr   <= addr_arr[grant_idx];
      register_write_data   <= data_arr[grant_idx];
    end else begin
      register_write_enable <= 1'b0;
    end
  end

  // Saturating count of contended cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (multi_valid && !wb_hold && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
